ledmatrix_framebuf: RTL
=======================

Name: ledmatrix_framebuf

Overview:
Double-buffered 8x8 frame store that sits directly upstream of the PMOD LED-matrix scan driver and drives its 64-bit pixels input.
- Producers write lines into a back buffer through a valid/ready port, then request a commit.
- The back buffer is copied to the displayed front buffer only on the driver's load pulse (frame boundary), so the scan never shows a torn frame.
- Also provides a multi-cycle back-buffer clear and a frame counter for animation timing.

Parameters:
FCNT_W, 16, width of the committed-frame counter (wraps modulo 2^FCNT_W)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (asserted at 0)
wr_valid  in  1  line-write request
wr_ready  out  1  line-write accepted when wr_valid && wr_ready
wr_line  in  3  back-buffer line index 0..7
wr_data  in  8  line contents, bit j = pixel j of that line
clr_start  in  1  single-cycle request to zero the back buffer
commit_valid  in  1  request to publish the back buffer
commit_ready  out  1  commit accepted when commit_valid && commit_ready
load  in  1  frame-boundary pulse from the scan driver, 1 cycle wide
pixels  out  64  front buffer, pixels[8*i +: 8] = line i
busy  out  1  high in CLEAR or PENDING
swap  out  1  registered 1-cycle pulse, the cycle after the front buffer updates
frame_cnt  out  FCNT_W  number of completed swaps

Behaviour:
- Reset (rst=0, async): front=0, back=0, pixels=0, state=IDLE, swap=0, frame_cnt=0, clear counter=0. wr_ready, commit_ready and busy are derived from state, giving 1/1/0 in reset.
- pixels is driven from the front register only. It changes only in the cycle following a load accepted in PENDING and never otherwise. The scan driver samples pixels live, so this rule is mandatory.
- States: IDLE, CLEAR, PENDING.
- Outputs by state:
  - wr_ready = (state==IDLE).
  - commit_ready = (state==IDLE) && !clr_start.
  - busy = (state!=IDLE).
- IDLE behaviour:
  - Accepted write: back[wr_line] <= wr_data, 1-cycle latency.
  - clr_start=1 -> CLEAR with line counter=0. A write in the same cycle still lands. Clear has priority over commit, and the commit is not accepted.
  - Accepted commit -> PENDING. A write in the same cycle is included in the committed frame.
- CLEAR: zeroes back[counter] each cycle, counter 0..7 (8 cycles), then -> IDLE. Front is untouched. load is ignored.
- PENDING: waits for load=1. On that edge: front <= back, state -> IDLE, frame_cnt <= frame_cnt+1 (wraps), swap=1 on the following cycle. back is retained (copy, not exchange), so incremental edits continue from the displayed frame.
- load while in IDLE or CLEAR has no effect.
- A commit accepted in the same cycle as load does not swap on that load. It waits for the next one (minimum one full frame).
- wr_valid, clr_start and commit_valid outside their accepting state are ignored, not queued. Producers must hold valid until ready.
- Reset mid-CLEAR or mid-PENDING: everything returns to reset values, and the pending commit is dropped.
- Latency: commit accept to pixels update = cycles until the next load + 1. Worst case about 64 clk cycles with the current scan driver (8 lines x 8).

Decomposition:
- Shared package: state encoding (IDLE/CLEAR/PENDING localparams), the constants MATRIX_LINES=8 and LINE_W=8, and the line-slice convention pixels[8*i +: 8].
- No sub-module. A single flat module with the back/front arrays, one FSM and one counter.

Test Plan:
- Reset then idle: release rst, run 100 cycles with periodic load -> pixels=64'h0, frame_cnt=0, swap never high, wr_ready=1.
- Write lines 0..7 with 8'h01<<i, commit, then pulse load 20 cycles later -> pixels stays 0 until the cycle after load, then = 64'h8040201008040201; swap=1 for exactly 1 cycle; frame_cnt=1; wr_ready=0 throughout PENDING.
- Commit and load in the same cycle -> no update on that load; update on the next load only, with frame_cnt=1 after it.
- With front=64'h8040201008040201, assert clr_start, then wr_valid immediately after -> busy for 8 cycles, wr_ready=0 for those 8 cycles, back all 0, pixels unchanged. Commit plus load then yields pixels=0.
- clr_start and commit_valid in the same cycle -> commit_ready=0, clear runs, no swap on the following loads.
- Assert rst mid-PENDING, then load -> pixels=0, frame_cnt=0, swap stays 0, state IDLE.

Source files
------------

// File: rtl/ledmatrix_framebuf_pkg.sv
// Shared definitions for the double-buffered 8x8 LED-matrix frame store.
// Line i of a packed frame occupies pixels[LINE_W*i +: LINE_W].
package ledmatrix_framebuf_pkg;

    localparam int unsigned MATRIX_LINES = 8;
    localparam int unsigned LINE_W       = 8;
    localparam int unsigned PIX_W        = MATRIX_LINES * LINE_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    typedef logic [$clog2(MATRIX_LINES)-1:0] line_idx_t;

endpackage

// File: rtl/ledmatrix_framebuf.sv
// Back/front frame store for the LED-matrix scan driver: producers edit the back
// buffer, and a commit is copied to the displayed front buffer only on a load pulse.
module ledmatrix_framebuf
    import ledmatrix_framebuf_pkg::*;
#(
    parameter int unsigned FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [2:0]        wr_line,
    input  logic [7:0]        wr_data,
    input  logic              clr_start,
    input  logic              commit_valid,
    output logic              commit_ready,
    input  logic              load,
    output logic [63:0]       pixels,
    output logic              busy,
    output logic              swap,
    output logic [FCNT_W-1:0] frame_cnt
);

    state_t            state, state_nx;
    logic [LINE_W-1:0] back [MATRIX_LINES];
    logic [PIX_W-1:0]  front;
    logic [PIX_W-1:0]  back_flat;
    line_idx_t         clr_cnt;
    logic              wr_fire;
    logic              commit_fire;
    logic              swap_now;

    always_comb begin
        wr_ready     = (state == ST_IDLE);
        commit_ready = (state == ST_IDLE) && !clr_start;
        busy         = (state != ST_IDLE);
        wr_fire      = wr_valid && wr_ready;
        commit_fire  = commit_valid && commit_ready;
        swap_now     = (state == ST_PENDING) && load;
        state_nx     = state;
        unique case (state)
            ST_IDLE: begin
                if (clr_start)
                    state_nx = ST_CLEAR;
                else if (commit_fire)
                    state_nx = ST_PENDING;
            end
            ST_CLEAR: begin
                if (clr_cnt == line_idx_t'(MATRIX_LINES - 1))
                    state_nx = ST_IDLE;
            end
            ST_PENDING: begin
                if (load)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        back_flat = '0;
        for (int unsigned i = 0; i < MATRIX_LINES; i++)
            back_flat[LINE_W*i +: LINE_W] = back[i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            front     <= '0;
            clr_cnt   <= '0;
            swap      <= 1'b0;
            frame_cnt <= '0;
            for (int unsigned i = 0; i < MATRIX_LINES; i++)
                back[i] <= '0;
        end else begin
            state <= state_nx;
            swap  <= swap_now;
            // Copy rather than exchange, so the back buffer keeps the shown frame.
            if (swap_now) begin
                front     <= back_flat;
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (state == ST_CLEAR) begin
                back[clr_cnt] <= '0;
                clr_cnt       <= clr_cnt + 1'b1;
            end else begin
                if (wr_fire)
                    back[wr_line] <= wr_data;
                if ((state == ST_IDLE) && clr_start)
                    clr_cnt <= '0;
            end
        end
    end

    assign pixels = front;

endmodule
